// File: rtl/stream_pack.sv
// stream_pack: gathers RATIO input beats into one wide word, with early close on last_b.
// The output word is registered; rdy_b is the only combinational input-to-output path.
module stream_pack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RATIO = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       data_b,
  input  logic                   vld_b,
  input  logic                   last_b,
  output logic                   rdy_b,
  output logic [WIDTH*RATIO-1:0] data_c,
  output logic [RATIO-1:0]       keep_c,
  output logic                   vld_c,
  input  logic                   rdy_c,
  output logic                   busy
);

  localparam int unsigned CNT_W  = $clog2(RATIO);
  localparam int unsigned WORD_W = WIDTH * RATIO;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_cand;
  logic              w_accept;
  logic              w_complete;
  logic [WORD_W-1:0] w_merged;
  logic [RATIO-1:0]  w_keep;

  // A completing beat may only enter when the output register is free or draining.
  assign w_cand     = (r_cnt == CNT_MAX) || last_b;
  assign rdy_b      = rst_n && (!w_cand || !vld_c || rdy_c);
  assign w_accept   = vld_b && rdy_b;
  assign w_complete = w_accept && w_cand;
  assign busy       = (r_cnt != '0) || vld_c;

  // Accumulated lanes below cnt, current beat in lane cnt, zeros above.
  always_comb begin
    w_merged = '0;
    w_keep   = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) < r_cnt) begin
        w_merged[i*WIDTH +: WIDTH] = r_acc[i*WIDTH +: WIDTH];
      end else if (CNT_W'(i) == r_cnt) begin
        w_merged[i*WIDTH +: WIDTH] = data_b;
      end
      w_keep[i] = (CNT_W'(i) <= r_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_complete) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_merged;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output register: a new word overwrites a draining one with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_c <= '0;
      keep_c <= '0;
      vld_c  <= 1'b0;
    end else if (w_complete) begin
      data_c <= w_merged;
      keep_c <= w_keep;
      vld_c  <= 1'b1;
    end else if (rdy_c) begin
      vld_c  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pack.sv
// Testbench for stream_pack (WIDTH=32, RATIO=2): directed scenarios plus a randomized
// run scored against a beat-list packing model.
module tb_stream_pack;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RATIO = 2;
  localparam int unsigned WW    = WIDTH * RATIO;

  typedef logic [WW+RATIO-1:0] word_t;  // {keep, data}

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_b;
  logic             vld_b;
  logic             last_b;
  logic             rdy_b;
  logic [WW-1:0]    data_c;
  logic [RATIO-1:0] keep_c;
  logic             vld_c;
  logic             rdy_c;
  logic             busy;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  word_t            got_q[$];
  word_t            exp_q[$];
  logic [WIDTH-1:0] mb_q[$];

  stream_pack #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk(clk), .rst_n(rst_n), .data_b(data_b), .vld_b(vld_b), .last_b(last_b),
    .rdy_b(rdy_b), .data_c(data_c), .keep_c(keep_c), .vld_c(vld_c), .rdy_c(rdy_c),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe handshakes on the falling edge; the model packs the accepted beats as a list.
  always @(negedge clk) begin
    if (!rst_n) begin
      mb_q.delete();
    end else begin
      if (vld_c && rdy_c) got_q.push_back({keep_c, data_c});
      if (vld_b && rdy_b) begin
        mb_q.push_back(data_b);
        if (mb_q.size() == RATIO || last_b) begin
          logic [WW-1:0]    d;
          logic [RATIO-1:0] k;
          d = '0;
          for (int j = 0; j < mb_q.size(); j++) d[j*WIDTH +: WIDTH] = mb_q[j];
          k = RATIO'((1 << mb_q.size()) - 1);
          exp_q.push_back({k, d});
          mb_q.delete();
        end
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++;
    if ({vld_c, keep_c, data_c} !== '0) $display("FAIL reset_out: got vld=%b keep=%b data=%h required 0", vld_c, keep_c, data_c);
    else n_pass++;
    n_total++;
    if ({rdy_b, busy} !== 2'b00) $display("FAIL reset_rdy_busy: got rdy_b=%b busy=%b required 0 0", rdy_b, busy);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({rdy_b, busy} !== 2'b10) $display("FAIL post_reset: got rdy_b=%b busy=%b required 1 0", rdy_b, busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    @(posedge clk); #1; rdy_c = 1'b1; vld_b = 1'b1; last_b = 1'b0; data_b = 32'h11111111;
    @(negedge clk);
    n_total++;
    if (rdy_b !== 1'b1) $display("FAIL basic_rdy: got %b required 1", rdy_b);
    else n_pass++;
    @(posedge clk); #1; data_b = 32'h22222222;
    @(negedge clk);
    n_total++;
    if ({busy, vld_c} !== 2'b10) $display("FAIL basic_mid: got busy=%b vld_c=%b required 1 0", busy, vld_c);
    else n_pass++;
    @(posedge clk); #1; vld_b = 1'b0;
    @(negedge clk);
    n_total++;
    if ({vld_c, keep_c, data_c} !== {1'b1, 2'b11, 64'h22222222_11111111})
      $display("FAIL basic_word: got vld=%b keep=%b data=%h required 1 11 2222222211111111", vld_c, keep_c, data_c);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if ({vld_c, busy} !== 2'b00) $display("FAIL basic_drain: got vld=%b busy=%b required 0 0", vld_c, busy);
    else n_pass++;
  endtask

  task automatic test_early_close;
    @(posedge clk); #1; vld_b = 1'b1; last_b = 1'b1; data_b = 32'hAAAA5555;
    @(posedge clk); #1; last_b = 1'b0; data_b = 32'hBEEF0001;
    @(negedge clk);
    n_total++;
    if ({vld_c, keep_c, data_c} !== {1'b1, 2'b01, 64'h00000000_AAAA5555})
      $display("FAIL early_word: got vld=%b keep=%b data=%h required 1 01 00000000aaaa5555", vld_c, keep_c, data_c);
    else n_pass++;
    @(posedge clk); #1; data_b = 32'hBEEF0002;
    @(posedge clk); #1; vld_b = 1'b0;
    @(negedge clk);
    n_total++;
    if ({keep_c, data_c} !== {2'b11, 64'hBEEF0002_BEEF0001})
      $display("FAIL early_next_lane0: got keep=%b data=%h required 11 beef0002beef0001", keep_c, data_c);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    got_q.delete();
    @(posedge clk); #1; rdy_c = 1'b0; vld_b = 1'b1; last_b = 1'b0; data_b = 32'h1;
    @(posedge clk); #1; data_b = 32'h2;
    @(posedge clk); #1; data_b = 32'h3;
    @(negedge clk);
    n_total++;
    if ({rdy_b, vld_c} !== 2'b11) $display("FAIL bp_first_lane: got rdy_b=%b vld_c=%b required 1 1", rdy_b, vld_c);
    else n_pass++;
    @(posedge clk); #1; data_b = 32'h4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({rdy_b, vld_c, data_c} !== {2'b01, 64'h00000002_00000001})
        $display("FAIL bp_stall: cycle %0d got rdy_b=%b vld=%b data=%h required 0 1 0000000200000001", c, rdy_b, vld_c, data_c);
      else n_pass++;
      @(posedge clk); #1;
    end
    rdy_c = 1'b1;
    @(negedge clk);
    n_total++;
    if (rdy_b !== 1'b1) $display("FAIL bp_release_rdy: got %b required 1", rdy_b);
    else n_pass++;
    @(posedge clk); #1; vld_b = 1'b0;
    @(negedge clk);
    n_total++;
    if ({vld_c, keep_c, data_c} !== {1'b1, 2'b11, 64'h00000004_00000003})
      $display("FAIL bp_new_word: got vld=%b keep=%b data=%h required 1 11 0000000400000003", vld_c, keep_c, data_c);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (got_q.size() !== 2) $display("FAIL bp_word_count: got %0d required 2", got_q.size());
    else n_pass++;
  endtask

  task automatic test_streaming;
    int pat[7] = '{1, 1, 0, 1, 0, 0, 1};
    int nxt = 1;
    int cyc = 0;
    got_q.delete();
    while (nxt <= 20 && cyc < 400) begin
      @(posedge clk); #1;
      rdy_c = pat[cyc % 7][0]; vld_b = 1'b1; last_b = 1'b0; data_b = WIDTH'(nxt);
      @(negedge clk);
      if (rdy_b) nxt++;
      cyc++;
    end
    @(posedge clk); #1; vld_b = 1'b0; rdy_c = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (got_q.size() !== 10) $display("FAIL stream_count: got %0d required 10", got_q.size());
    else n_pass++;
    for (int k = 1; k <= 10 && k <= got_q.size(); k++) begin
      word_t w;
      w = {2'b11, WIDTH'(2 * k), WIDTH'(2 * k - 1)};
      n_total++;
      if (got_q[k-1] !== w) $display("FAIL stream_word%0d: got %h required %h", k, got_q[k-1], w);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1; rdy_c = 1'b1; vld_b = 1'b1; last_b = 1'b1; data_b = 32'hC0DE0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin vld_b = 1'b0; last_b = 1'b0; end
      else data_b = 32'hC0DE0000 + WIDTH'(k + 1);
      @(negedge clk);
      n_total++;
      if ({vld_c, keep_c, data_c} !== {1'b1, 2'b01, 32'h0, 32'hC0DE0000 + WIDTH'(k)})
        $display("FAIL b2b_word%0d: got vld=%b keep=%b data=%h required 1 01 lane0 %h", k, vld_c, keep_c, data_c, 32'hC0DE0000 + WIDTH'(k));
      else n_pass++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (vld_c !== 1'b0) $display("FAIL b2b_end: got vld=%b required 0", vld_c);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word;
    @(posedge clk); #1; rdy_c = 1'b1; vld_b = 1'b1; last_b = 1'b0; data_b = 32'h12345678;
    @(posedge clk); #1; vld_b = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b required 1", busy);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b0; vld_b = 1'b1; data_b = 32'hDEADDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({vld_c, rdy_b, busy} !== 3'b000) $display("FAIL rst_mid_hold%0d: got vld=%b rdy_b=%b busy=%b required 0 0 0", c, vld_c, rdy_b, busy);
      else n_pass++;
    end
    @(posedge clk); #1; rst_n = 1'b1; data_b = 32'hA;
    @(posedge clk); #1; data_b = 32'hB;
    @(posedge clk); #1; vld_b = 1'b0;
    @(negedge clk);
    n_total++;
    if ({vld_c, keep_c, data_c} !== {1'b1, 2'b11, 64'h0000000B_0000000A})
      $display("FAIL rst_mid_after: got vld=%b keep=%b data=%h required 1 11 0000000b0000000a", vld_c, keep_c, data_c);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      vld_b  = ($urandom_range(0, 3) != 0);
      last_b = ($urandom_range(0, 3) == 0);
      data_b = $urandom;
      rdy_c  = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1; vld_b = 1'b1; last_b = 1'b1; data_b = 32'hF00DF00D; rdy_c = 1'b1;
    @(negedge clk);
    while (!rdy_b) @(negedge clk);
    @(posedge clk); #1; vld_b = 1'b0; last_b = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (got_q.size() !== exp_q.size() || exp_q.size() < 20)
      $display("FAIL rand_count: got %0d words required %0d (at least 20)", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_total++;
      if (got_q[k] !== exp_q[k]) $display("FAIL rand_word%0d: got %h required %h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL rand_idle: got busy=%b required 0", busy);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; vld_b = 1'b0; last_b = 1'b0; data_b = '0; rdy_c = 1'b1;
    test_reset();
    test_basic();
    test_early_close();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/stream_pack.md
# stream_pack

Downstream width-packing stage for the 32-bit valid/ready pipeline. Consumes the `data_b`/`vld_b`/`rdy_b` stream produced by the bubble-collapsing register stage. Gathers RATIO consecutive beats into one wide word and emits it on a registered valid/ready output. A `last_b` marker closes a word early, and `keep_c` flags which lanes are populated.

## Interface
- WIDTH, 32, bits per input beat.
- RATIO, 2, input beats per output word; legal range 2..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_b  in  WIDTH  input beat.
- vld_b  in  1  input beat valid.
- last_b  in  1  qualifies the beat; 1 = final beat of the current word.
- rdy_b  out  1  stage can accept a beat this cycle.
- data_c  out  WIDTH*RATIO  packed word; lane i = data_c[i*WIDTH +: WIDTH].
- keep_c  out  RATIO  lane-populated mask for data_c, LSB = lane 0.
- vld_c  out  1  packed word valid.
- rdy_c  in  1  downstream accepts the word.
- busy  out  1  partial word held or output word pending.

## Operation
- Accept condition: accept = vld_b && rdy_b.
- Storage: accumulator register acc (WIDTH*RATIO), lane counter cnt (clog2(RATIO) bits), output register (data_c, keep_c, vld_c).
- Lane placement: the accepted beat is written to lane cnt of acc. Lane 0 is the first beat, so the layout is little-endian.
- Completing beat: an accepted beat completes the word when cnt == RATIO-1 or last_b == 1. On completion:
  - data_c loads the merged word (acc plus the current beat in lane cnt).
  - Lanes above cnt are forced to 0.
  - keep_c loads the low (cnt+1) bits set.
  - vld_c is set to 1.
  - cnt returns to 0 and acc clears.
- Non-completing beat: cnt increments. The output register is untouched.
- Ready rule: rdy_b = rst_n && (!completing_candidate || !vld_c || rdy_c). Here completing_candidate = (cnt == RATIO-1) || last_b.
  - Non-completing beats are accepted while an output word is stalled.
- Output drain: vld_c clears on vld_c && rdy_c unless a new word loads in the same cycle. Simultaneous drain and load replaces the word with no bubble.
- busy = (cnt != 0) || vld_c.

## Timing
- Reset values while rst_n = 0, applied immediately (asynchronous):
  - cnt = 0, acc = 0.
  - data_c = 0, keep_c = 0, vld_c = 0.
  - rdy_b = 0, busy = 0.
- Latency: the word is presented on vld_c the cycle after the completing beat is accepted.
- Throughput: one input beat per cycle sustained when rdy_c = 1. One output word per RATIO cycles for full words. One word per cycle when every beat has last_b = 1.
- rdy_b is combinational from rdy_c, last_b, cnt and vld_c. There is no other input-to-output combinational path.
- While vld_c && !rdy_c, data_c and keep_c hold stable. vld_c never drops without a handshake.
- last_b at cnt = 0 emits a single-lane word with keep_c = 1.
- last_b on a beat that is not accepted has no effect.
- cnt == RATIO-1 with vld_c = 1 and rdy_c = 0 gives rdy_b = 0. The beat is stalled, not dropped.
- Reset mid-word discards the partial word and any pending output word. The first beat after reset lands in lane 0.
- Width rule: cnt never exceeds RATIO-1. keep_c is always contiguous from bit 0.

## Test plan
All scenarios use WIDTH = 32, RATIO = 2.
- Basic pack: beats 0x11111111, 0x22222222 with rdy_c = 1 and last_b = 0 → one cycle after the second accept, data_c = 0x22222222_11111111, keep_c = 2'b11, vld_c = 1 for one cycle.
- Early close: beat 0xAAAA5555 with last_b = 1 at cnt = 0 → data_c = 0x00000000_AAAA5555, keep_c = 2'b01. The next beat lands in lane 0.
- Backpressure: hold rdy_c = 0 with a word pending.
  - The next first-lane beat is accepted (rdy_b = 1).
  - The second-lane beat sees rdy_b = 0 and data_c stays stable.
  - Raising rdy_c accepts that beat in the same cycle; the new word appears the next cycle with no lost data.
- Streaming: continuous vld_b with incrementing data 1..20 and rdy_c toggling 1,1,0,1,0,0,1 → 10 words out in order, word k = {2k, 2k-1}, no duplicates or drops.
- Back-to-back last: 4 beats all with last_b = 1 and rdy_c = 1 → 4 consecutive vld_c cycles, each with keep_c = 2'b01.
- Reset mid-word: accept 0x12345678 (cnt = 1), pulse rst_n low for 3 cycles → during reset vld_c = 0, rdy_b = 0, busy = 0. After reset, beats 0xA, 0xB give data_c = 0x0000000B_0000000A.
